// File: rtl/program_loader.sv
// program_loader: receives a framed byte stream (length, opcode/literal pairs, XOR checksum)
// and writes 15-bit instructions from address 0, holding the CPU in reset until a clean load.
`default_nettype none

module program_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        im_we,
  output logic [7:0]  im_addr,
  output logic [14:0] im_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [8:0]  words_loaded
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    HI   = 3'd2,
    LO   = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  addr_q, addr_d;
  logic [8:0]  words_q, words_d;
  logic        im_we_q, im_we_d;
  logic [7:0]  im_addr_q, im_addr_d;
  logic [14:0] im_wdata_q, im_wdata_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        xfer;
  logic [8:0]  target;
  logic        active_d;

  assign xfer   = in_valid & in_ready_q;
  // A length byte of zero encodes a full 256-word image.
  assign target = (len_q == 8'd0) ? 9'd256 : {1'b0, len_q};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    opcode_d   = opcode_q;
    csum_d     = csum_q;
    addr_d     = addr_q;
    words_d    = words_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN;
          words_d = 9'd0;
          addr_d  = 8'd0;
          csum_d  = 8'd0;
        end
      end
      LEN: begin
        if (xfer) begin
          len_d   = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = HI;
        end
      end
      HI: begin
        if (xfer) begin
          if (in_data[7]) begin
            state_d = ERR;
          end else begin
            opcode_d = in_data[6:0];
            csum_d   = csum_q ^ in_data;
            state_d  = LO;
          end
        end
      end
      LO: begin
        if (xfer) begin
          csum_d     = csum_q ^ in_data;
          im_we_d    = 1'b1;
          im_addr_d  = addr_q;
          im_wdata_d = {opcode_q, in_data};
          addr_d     = addr_q + 8'd1;
          words_d    = words_q + 9'd1;
          state_d    = (words_q + 9'd1 == target) ? CSUM : HI;
        end
      end
      CSUM: begin
        if (xfer) begin
          state_d = (in_data == csum_q) ? DONE : ERR;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status flags are derived from the next state so they register alongside it.
    active_d   = (state_d == LEN) || (state_d == HI) || (state_d == LO) || (state_d == CSUM);
    in_ready_d = active_d;
    busy_d     = active_d;
    cpu_hold_d = (state_d != DONE);
    done_d     = (state_d == DONE);
    error_d    = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      len_q      <= 8'd0;
      opcode_q   <= 7'd0;
      csum_q     <= 8'd0;
      addr_q     <= 8'd0;
      words_q    <= 9'd0;
      im_we_q    <= 1'b0;
      im_addr_q  <= 8'd0;
      im_wdata_q <= 15'd0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      opcode_q   <= opcode_d;
      csum_q     <= csum_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign im_we        = im_we_q;
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench; expected writes are queued as bytes are driven
// and popped when the loader strobes im_we.
`default_nettype none

module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [14:0] im_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;
  logic [7:0]  hi_a[256];
  logic [7:0]  lo_a[256];

  always #5 clk = ~clk;

  program_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each write must match the next queued {words_loaded, addr, data} entry.
  always @(negedge clk) begin
    if (reset === 1'b1 && im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", 64'(im_we), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("write", {words_loaded, im_addr, im_wdata}, 64'(mon_e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctrl"}, {in_ready, im_we, cpu_hold, busy, done, error}, 64'b001000);
    check({tag, "_data"}, {im_addr, im_wdata, words_loaded}, 64'd0);
  endtask

  // Called just after a rising edge; returns just after the edge that took the byte.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int gap;
    int waited;
    gap = rnd ? int'($urandom_range(0, 2)) : 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_flags", {busy, cpu_hold, in_ready, done, error}, 64'b11100);
    check("start_words", 64'(words_loaded), 64'd0);
  endtask

  task automatic run_load(input int n, input bit bad, input bit rnd, input bit mid_start);
    logic [7:0] cs;
    cs = 8'(n);
    pulse_start();
    send_byte(8'(n), rnd);
    for (int i = 0; i < n; i++) begin
      send_byte(hi_a[i], rnd);
      cs = cs ^ hi_a[i];
      if (mid_start && i == 0) begin
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
      exp_q.push_back({9'(i + 1), 8'(i), hi_a[i][6:0], lo_a[i]});
      send_byte(lo_a[i], rnd);
      cs = cs ^ lo_a[i];
    end
    send_byte(bad ? (cs ^ 8'h01) : cs, rnd);
    check("end_flags", {done, error, cpu_hold, busy, in_ready},
          {!bad, bad, bad, 1'b0, 1'b0});
    check("end_words", 64'(words_loaded), 64'(n));
    check("end_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic set_nominal();
    hi_a[0] = 8'h01; lo_a[0] = 8'h05;
    hi_a[1] = 8'h02; lo_a[1] = 8'h0A;
  endtask

  initial begin
    int waited;
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1 check_reset_vals("reset");
    reset = 1'b1;
    @(posedge clk);
    #1 check_reset_vals("idle");

    set_nominal();
    run_load(2, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("done_sticky", {done, cpu_hold, busy}, 64'b100);

    run_load(2, 1'b1, 1'b0, 1'b0);

    // Format error: opcode byte with bit 7 set.
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h80, 1'b0);
    check("fmt_flags", {done, error, cpu_hold, busy, in_ready}, 64'b01100);
    check("fmt_words", 64'(words_loaded), 64'd0);
    repeat (3) @(posedge clk);
    #1;

    run_load(2, 1'b0, 1'b1, 1'b0);
    run_load(2, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 256; i++) begin
      hi_a[i] = 8'($urandom_range(0, 127));
      lo_a[i] = 8'($urandom_range(0, 255));
    end
    run_load(256, 1'b0, 1'b0, 1'b0);

    // Reset asserted after the first word is written.
    set_nominal();
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(hi_a[0], 1'b0);
    exp_q.push_back({9'd1, 8'd0, hi_a[0][6:0], lo_a[0]});
    send_byte(lo_a[0], 1'b0);
    waited = 0;
    while (exp_q.size() != 0 && waited < 5) begin
      @(negedge clk);
      waited++;
    end
    check("first_word_seen", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 check_reset_vals("async_rst");
    @(posedge clk);
    #1 check_reset_vals("held_rst");
    reset = 1'b1;
    @(posedge clk);
    #1;
    run_load(2, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
